branch_condition_unit: RTL
==========================

Name: branch_condition_unit

Overview:
Parametrised successor to the single-output zero detector. It registers a full flag set (Z, N, C, V) from the ALU result and carry/overflow inputs, then evaluates one of eight branch conditions with one cycle of latency. It supports pipeline stall and flush, and keeps saturating branch statistics counters. It sits between the EX-stage ALU and the PC-select logic.

Parameters:
WIDTH, 32, ALU result width in bits (>=2)
CNT_W, 16, width of each statistics counter (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  alu_out/cond hold a branch instruction this cycle
stall  input  1  hold all state (pipeline freeze)
flush  input  1  kill the instruction being captured this cycle
cnt_clear  input  1  synchronous clear of both statistics counters
alu_out  input  WIDTH  ALU result (rs - rt for compares)
carry_in  input  1  ALU borrow from subtract (1 = unsigned rs < rt)
overflow_in  input  1  ALU signed overflow
cond  input  3  condition select
out_valid  output  1  taken/flags correspond to a captured branch
taken  output  1  branch condition true
zero  output  1  registered Z flag
negative  output  1  registered N flag
carry  output  1  registered C flag
overflow  output  1  registered V flag
branch_cnt  output  CNT_W  branches evaluated
taken_cnt  output  CNT_W  branches taken

Behaviour:
- Single clock "clock"; reset "reset" is asynchronous and active-high. While reset is high, every output and register is 0.
- Flag compute (combinational, internal):
  - Z = (alu_out == 0)
  - N = alu_out[MSB]
  - C = carry_in
  - V = overflow_in
- cond encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 LT: N^V
  - 3 GE: !(N^V)
  - 4 LTU: C
  - 5 GEU: !C
  - 6 ALWAYS: 1
  - 7 NEVER: 0
- Latency is 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- Per-edge priority is flush > stall > normal capture.
  - flush=1: out_valid<=0 and taken<=0. Flags and counters are unchanged. This applies even if stall=1.
  - stall=1 (no flush): every register holds, including out_valid and taken.
  - Normal capture, in_valid=1:
    - out_valid<=1.
    - Flags<=computed values.
    - taken<=evaluated cond.
    - branch_cnt increments by 1.
    - taken_cnt increments by 1 if the evaluated cond is true.
  - Normal capture, in_valid=0: out_valid<=0 and taken<=0. Flags hold their last captured values. Counters hold.
- Counters:
  - Unsigned and saturating at 2^CNT_W-1; they never wrap.
  - taken_cnt <= branch_cnt always.
  - cnt_clear=1 sets both counters to 0 on that edge. Clear wins over a simultaneous increment, and that increment is discarded.
  - cnt_clear is honoured even while stall=1 or flush=1.
- The unit has no combinational path from inputs to outputs.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first capture after deassertion behaves normally.

Test Plan:
- Reset/idle: assert reset, then hold in_valid=0 for 3 clocks -> all outputs 0 and counters 0.
- EQ/NE: alu_out=0, cond=0, in_valid=1 -> next cycle out_valid=1, taken=1, zero=1, branch_cnt=1, taken_cnt=1. Then alu_out=5, cond=1 -> taken=1, zero=0, counters 2/2.
- Signed/unsigned (WIDTH=32): alu_out=0x8000_0000, overflow_in=1, carry_in=1, cond=2 -> taken=0 (N^V=0). Same inputs with cond=4 -> taken=1.
- Stall/flush: capture cond=6, then stall=1 for 2 cycles with new inputs -> outputs and counters frozen. Then flush=1 with stall=1 and in_valid=1 -> out_valid=0, taken=0, counters unchanged.
- Saturation/clear (CNT_W=2): 5 consecutive cond=6 captures -> branch_cnt=3, taken_cnt=3. Then cnt_clear=1 with in_valid=1 -> counters 0, out_valid=1.
- Async reset mid-stream: assert reset between edges while out_valid=1 -> all outputs drop to 0 before the next rising edge.

Source files
------------

// File: rtl/branch_condition_unit.sv
// Registers Z/N/C/V from the EX-stage ALU and resolves one of eight branch conditions; 1-cycle latency.
// No backpressure: stall freezes every register, flush kills the capture; counters saturate.
module branch_condition_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clear,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic [2:0]       cond,
  output logic             out_valid,
  output logic             taken,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic zeroNow;
  logic negNow;
  logic condTrue;
  logic doCapture;

  assign zeroNow   = (alu_out == '0);
  assign negNow    = alu_out[WIDTH-1];
  assign doCapture = in_valid && !stall && !flush;

  always_comb begin
    condTrue = 1'b0;
    unique case (cond)
      3'd0: condTrue = zeroNow;
      3'd1: condTrue = !zeroNow;
      3'd2: condTrue = negNow ^ overflow_in;
      3'd3: condTrue = !(negNow ^ overflow_in);
      3'd4: condTrue = carry_in;
      3'd5: condTrue = !carry_in;
      3'd6: condTrue = 1'b1;
      3'd7: condTrue = 1'b0;
      default: condTrue = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      taken     <= in_valid && condTrue;
      if (in_valid) begin
        zero     <= zeroNow;
        negative <= negNow;
        carry    <= carry_in;
        overflow <= overflow_in;
      end
    end
  end

  // Clear is independent of stall/flush and beats any same-edge increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (cnt_clear) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (doCapture) begin
      if (branch_cnt != CntMax) branch_cnt <= branch_cnt + 1'b1;
      if (condTrue && taken_cnt != CntMax) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule
